// File: rtl/requant_div.sv
// Sequential signed-by-unsigned restoring divider that requantizes a DW-bit
// accumulator by a VW-bit scale into a saturated QW-bit signed operand.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// CALC  | one restoring quotient bit per enabled edge
// FIX   | apply sign / saturation / divide-by-zero, register outputs
// DONE  | result held until out_ready handshake
module requant_div #(
    parameter int DW = 26,
    parameter int VW = 8,
    parameter int QW = 18
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          ovf,
    output logic          dbz
);

    localparam int CW = $clog2(DW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [QW-1:0] Q_MAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};

    logic [1:0]    state;
    logic          sgn;
    logic [DW-1:0] mag;
    logic [DW-1:0] qreg;
    logic [VW-1:0] dvs;
    logic [VW-1:0] prem;
    logic [CW-1:0] cnt;

    logic [VW:0]   shifted;
    logic [VW-1:0] diff;
    logic          ge;
    logic          pos_ovf;
    logic          neg_ovf;
    logic [QW-1:0] q_lo;

    always_comb begin
        shifted = {prem, mag[DW-1]};
        ge      = shifted >= {1'b0, dvs};
        // partial remainder is always below the divisor, so VW bits suffice
        diff    = shifted[VW-1:0] - dvs;
        pos_ovf = |qreg[DW-1:QW-1];
        neg_ovf = (|qreg[DW-1:QW]) | (qreg[QW-1] & (|qreg[QW-2:0]));
        q_lo    = qreg[QW-1:0];
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            sgn       <= 1'b0;
            mag       <= '0;
            qreg      <= '0;
            dvs       <= '0;
            prem      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else if (ce) begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sgn   <= dividend[DW-1];
                        mag   <= dividend[DW-1] ? (~dividend + 1'b1) : dividend;
                        dvs   <= divisor;
                        prem  <= '0;
                        qreg  <= '0;
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // a zero divisor passes through CALC once without stepping
                    if (dvs == '0) begin
                        state <= S_FIX;
                    end else begin
                        mag  <= {mag[DW-2:0], 1'b0};
                        qreg <= {qreg[DW-2:0], ge};
                        prem <= ge ? diff : shifted[VW-1:0];
                        if (cnt == CW'(DW-1)) begin
                            state <= S_FIX;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    if (dvs == '0) begin
                        quotient  <= sgn ? Q_MIN : Q_MAX;
                        remainder <= '0;
                        ovf       <= 1'b0;
                        dbz       <= 1'b1;
                    end else begin
                        remainder <= prem;
                        dbz       <= 1'b0;
                        if (!sgn && pos_ovf) begin
                            quotient <= Q_MAX;
                            ovf      <= 1'b1;
                        end else if (sgn && neg_ovf) begin
                            quotient <= Q_MIN;
                            ovf      <= 1'b1;
                        end else begin
                            quotient <= sgn ? (~q_lo + 1'b1) : q_lo;
                            ovf      <= 1'b0;
                        end
                    end
                    state <= S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_requant_div.sv
// Self-checking bench for requant_div: vector table plus scoreboard queue,
// with hand-written backpressure, clock-enable stall and mid-operation reset.
module tb_requant_div;

    typedef struct {
        logic [25:0] dvd;
        logic [7:0]  dvs;
        logic [17:0] q;
        logic [7:0]  r;
        logic        ovf;
        logic        dbz;
        int          lat;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] quotient;
    logic [7:0]  remainder;
    logic        ovf;
    logic        dbz;

    int checks;
    int failures;
    vec_t sbq[$];
    vec_t tbl[14];

    requant_div dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [25:0] a, input logic [7:0] b);
        vec_t   v;
        longint sa;
        longint m;
        longint qm;
        v.dvd = a;
        v.dvs = b;
        sa = longint'($signed(a));
        m  = (sa < 0) ? -sa : sa;
        if (b == 8'd0) begin
            v.q   = (sa < 0) ? 18'h20000 : 18'h1FFFF;
            v.r   = 8'd0;
            v.ovf = 1'b0;
            v.dbz = 1'b1;
            v.lat = 2;
        end else begin
            qm    = m / longint'(b);
            v.r   = 8'(m % longint'(b));
            v.dbz = 1'b0;
            v.lat = 27;
            if (sa >= 0 && qm > 131071) begin
                v.q = 18'h1FFFF; v.ovf = 1'b1;
            end else if (sa < 0 && qm > 131072) begin
                v.q = 18'h20000; v.ovf = 1'b1;
            end else begin
                v.q = 18'((sa < 0) ? -qm : qm); v.ovf = 1'b0;
            end
        end
        return v;
    endfunction

    // Issue one operation; optional ce stall inside CALC and result backpressure.
    task automatic do_op(input vec_t v, input string tag, input int stall_at,
                         input int stall_len, input int hold);
        vec_t e;
        int   n;
        logic busy_ok;
        logic hold_ok;
        sbq.push_back(v);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_accept_wait"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = v.dvd;
        divisor  = v.dvs;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 200) begin
            ce = (n >= stall_at && n < stall_at + stall_len) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            n++;
            if (!out_valid && in_ready) busy_ok = 1'b0;
        end
        ce = 1'b1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_in_ready_busy"}, 32'(busy_ok && !in_ready), 32'd1);
        e = sbq.pop_front();
        chk({tag, "_latency"}, 32'(n), 32'(e.lat + stall_len));
        chk({tag, "_quotient"}, 32'(quotient), 32'(e.q));
        chk({tag, "_remainder"}, 32'(remainder), 32'(e.r));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        chk({tag, "_dbz"}, 32'(dbz), 32'(e.dbz));
        if (hold > 0) begin
            hold_ok = 1'b1;
            in_valid = 1'b1;
            dividend = 26'd77;
            divisor  = 8'd5;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!out_valid || in_ready || quotient !== e.q || remainder !== e.r)
                    hold_ok = 1'b0;
            end
            chk({tag, "_held_stable"}, 32'(hold_ok), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_drain_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_kept_quotient"}, 32'(quotient), 32'(e.q));
    endtask

    initial begin
        vec_t v;
        int   n;
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        tbl[0]  = '{26'd1000,     8'd7,   18'd142,    8'd6, 1'b0, 1'b0, 27};
        tbl[1]  = '{26'h3FFFC18,  8'd7,   18'h3FF72,  8'd6, 1'b0, 1'b0, 27};
        tbl[2]  = '{26'h1FFFFFF,  8'd1,   18'h1FFFF,  8'd0, 1'b1, 1'b0, 27};
        tbl[3]  = '{26'h2000000,  8'd255, 18'h20000,  8'd2, 1'b1, 1'b0, 27};
        tbl[4]  = '{26'd5,        8'd0,   18'h1FFFF,  8'd0, 1'b0, 1'b1, 2};
        tbl[5]  = '{26'h3FFFFFB,  8'd0,   18'h20000,  8'd0, 1'b0, 1'b1, 2};
        tbl[6]  = '{26'd0,        8'd5,   18'd0,      8'd0, 1'b0, 1'b0, 27};
        tbl[7]  = '{26'h3FE0000,  8'd1,   18'h20000,  8'd0, 1'b0, 1'b0, 27};
        tbl[8]  = '{26'h0020000,  8'd1,   18'h1FFFF,  8'd0, 1'b1, 1'b0, 27};
        tbl[9]  = '{26'd131071,   8'd1,   18'h1FFFF,  8'd0, 1'b0, 1'b0, 27};
        tbl[10] = '{26'h3FFFFF9,  8'd2,   18'h3FFFD,  8'd1, 1'b0, 1'b0, 27};
        tbl[11] = '{26'd255,      8'd255, 18'd1,      8'd0, 1'b0, 1'b0, 27};
        tbl[12] = '{26'h3FDFFFF,  8'd1,   18'h20000,  8'd0, 1'b1, 1'b0, 27};
        tbl[13] = '{26'd0,        8'd0,   18'h1FFFF,  8'd0, 1'b0, 1'b1, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_outputs", {quotient, remainder, ovf, dbz}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++)
            do_op(tbl[i], $sformatf("vec%0d", i), 1000, 0, 0);

        for (int i = 0; i < 6; i++) begin
            v = model(26'($urandom) >>> $urandom_range(0, 20), 8'($urandom_range(0, 255)));
            do_op(v, $sformatf("rnd%0d", i), 1000, 0, 0);
        end

        v = '{26'd200, 8'd3, 18'd66, 8'd2, 1'b0, 1'b0, 27};
        do_op(v, "backpressure", 1000, 0, 10);
        do_op(v, "ce_stall", 10, 5, 0);

        in_valid = 1'b1;
        dividend = 26'd1000;
        divisor  = 8'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midop_busy", 32'(in_ready), 32'd0);
        reset_n = 1'b0;
        #2;
        chk("midop_reset_in_ready", 32'(in_ready), 32'd1);
        chk("midop_reset_out_valid", 32'(out_valid), 32'd0);
        chk("midop_reset_outputs", {quotient, remainder, ovf, dbz}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chk("midop_result_lost", 32'(n), 32'd0);
        v = '{26'd9, 8'd3, 18'd3, 8'd0, 1'b0, 1'b0, 27};
        do_op(v, "after_reset", 1000, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
